// File: rtl/mac16_issue_ctrl.sv
// mac16_issue_ctrl: issue/return controller for the 16-lane pipelined MAC tree.
//
// Start requests are accepted only when a FIFO slot is guaranteed for the sum.
// Each accepted request injects a token into a shift register that matches the
// tree latency. When a token reaches the end of the pipe, the tree output is
// captured into a small result FIFO. That FIFO drives a valid/ready port.
//
// Ports
//   clk       in   1       single clock, rising edge
//   reset     in   1       asynchronous active-low reset, clears all state
//   start     in   1       request to issue one dot product
//   flush     in   1       discard all in-flight and queued results
//   busy      out  1       start is not accepted this cycle
//   issue     out  1       tree samples its operands at this edge
//   res_in    in   DATA_W  tree output (adder root)
//   result    out  DATA_W  FIFO head, or last popped value when empty
//   valid     out  1       result holds an unread sum
//   ready     in   1       consumer takes result this cycle
//   inflight  out  CNT_W   tokens currently inside the tree
//   err       out  1       sticky overflow/underflow indicator
module mac16_issue_ctrl #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LATENCY    = 5,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              flush,
    output logic              busy,
    output logic              issue,
    input  logic [DATA_W-1:0] res_in,
    output logic [DATA_W-1:0] result,
    output logic              valid,
    input  logic              ready,
    output logic [CNT_W-1:0]  inflight,
    output logic              err
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StActive, StFull, StFlush} state_e;

    state_e              state_q, state_d;
    logic [LATENCY-1:0]  tok_q, tok_d;
    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0]   mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [DATA_W-1:0]   last_q, last_d;
    logic                err_q, err_d;

    logic [CNT_W:0]      credit_sum;
    logic                credit_full;
    logic                fifo_full;
    logic                push_req;
    logic                do_push;
    logic                pop;

    // Token count inside the tree.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + CNT_W'(tok_q[i]);
        end
    end

    // Each in-flight token already owns a FIFO slot. Accepting another
    // request is therefore safe only while tokens plus entries stay below the depth.
    assign credit_sum  = {1'b0, inflight} + {1'b0, count_q};
    assign credit_full = credit_sum >= (CNT_W + 1)'(FIFO_DEPTH);
    assign fifo_full   = count_q == CNT_W'(FIFO_DEPTH);
    assign valid       = count_q != '0;
    assign pop         = valid & ready;
    assign push_req    = tok_q[LATENCY-1] & (state_q != StFlush);
    assign result      = valid ? mem_q[rd_ptr_q] : last_q;
    assign err         = err_q;

    // FSM output process: busy depends on registers only, never on start.
    always_comb begin
        busy  = (state_q == StFlush) | credit_full;
        issue = start & ~busy;
    end

    // FSM next-state process.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (issue) state_d = StActive;
            end
            StActive: begin
                if (credit_full) begin
                    state_d = StFull;
                end else if (!issue && inflight == '0 && !valid) begin
                    state_d = StIdle;
                end
            end
            StFull: begin
                if (pop) state_d = StActive;
            end
            StFlush: begin
                if (!flush && inflight == '0) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (flush) state_d = StFlush;
    end

    // Token pipe and result FIFO next state.
    always_comb begin
        tok_d    = {tok_q[LATENCY-2:0], issue};
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        last_d   = last_q;
        err_d    = err_q;
        do_push  = 1'b0;

        if (pop) last_d = mem_q[rd_ptr_q];

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // A push at full is still legal when a pop frees the slot on the same edge.
            do_push = push_req & (~fifo_full | pop);
            // pop is qualified by valid, so a pop from empty cannot occur and
            // only an overflowing push can raise err.
            if (push_req & fifo_full & ~pop) err_d = 1'b1;
            if (do_push) begin
                mem_d[wr_ptr_q] = res_in;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (do_push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (!do_push && pop) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            tok_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            tok_q    <= tok_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
            err_q    <= err_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: tb/tb_mac16_issue_ctrl.sv
// tb_mac16_issue_ctrl: self-checking bench for mac16_issue_ctrl.
// A reference model uses queues of outstanding issues and queued sums.
// Table-driven rows cover the single-issue case. Hand-written sequences cover
// credit stall, drain, push/pop at the same time, flush and async reset.
// Random traffic follows the directed sequences.
module tb_mac16_issue_ctrl;

    localparam int LAT   = 5;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] res_in = '0;
    logic        busy, issue, valid, err;
    logic [31:0] result;
    logic [3:0]  inflight;

    mac16_issue_ctrl #(
        .DATA_W    (32),
        .LATENCY   (LAT),
        .FIFO_DEPTH(DEPTH),
        .CNT_W     (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .flush   (flush),
        .busy    (busy),
        .issue   (issue),
        .res_in  (res_in),
        .result  (result),
        .valid   (valid),
        .ready   (ready),
        .inflight(inflight),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Reference model state.
    typedef struct {
        int unsigned iss;
        logic [31:0] tag;
    } tok_t;

    tok_t        tokq[$];
    logic [31:0] fifo[$];
    logic [31:0] last_pop;
    bit          flushing;
    int unsigned cyc;
    logic [31:0] next_tag;

    // Expectations and inputs of the current cycle, used at the next edge.
    bit          land_now, e_busy, e_issue, e_valid, s_flush, s_ready;
    logic [31:0] e_result;
    int          e_inflight;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       start;
        logic       flush;
        logic       ready;
        logic       busy;
        logic       issue;
        logic       valid;
        logic [3:0] inflight;
        logic [31:0] result;
    } vec_t;

    vec_t t1_tab [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        tokq.delete();
        fifo.delete();
        last_pop = '0;
        flushing = 1'b0;
    endtask

    // Drive one cycle's inputs at the falling edge and compare outputs with the model.
    task automatic drive_and_check(input logic s, input logic f, input logic r);
        @(negedge clk);
        land_now = (tokq.size() > 0) && (tokq[0].iss + LAT == cyc + 1);
        // The tree output is only meaningful when a sum returns. Otherwise it is noise.
        res_in = land_now ? tokq[0].tag : $urandom;
        start  = s;
        flush  = f;
        ready  = r;
        #1;
        e_inflight = tokq.size();
        e_valid    = fifo.size() > 0;
        e_result   = e_valid ? fifo[0] : last_pop;
        e_busy     = flushing || (tokq.size() + fifo.size() >= DEPTH);
        e_issue    = s && !e_busy;
        s_flush    = f;
        s_ready    = r;
        chk("busy", 32'(busy), 32'(e_busy));
        chk("issue", 32'(issue), 32'(e_issue));
        chk("valid", 32'(valid), 32'(e_valid));
        chk("inflight", 32'(inflight), 32'(e_inflight));
        chk("result", result, e_result);
        chk("err", 32'(err), 32'd0);
    endtask

    // Advance the model across one rising edge.
    task automatic clock_edge();
        int pre_inflight;
        @(posedge clk);
        pre_inflight = tokq.size();
        if (s_flush) begin
            if (e_valid && s_ready) last_pop = fifo[0];
            fifo.delete();
        end else if (!flushing) begin
            if (e_valid && s_ready) last_pop = fifo.pop_front();
            if (land_now) fifo.push_back(tokq[0].tag);
        end
        if (land_now) void'(tokq.pop_front());
        if (e_issue) begin
            tokq.push_back('{iss: cyc + 1, tag: next_tag});
            next_tag = next_tag + 32'd1;
        end
        if (s_flush) flushing = 1'b1;
        else if (flushing && pre_inflight == 0) flushing = 1'b0;
        cyc++;
    endtask

    task automatic cycle(input logic s, input logic f, input logic r);
        drive_and_check(s, f, r);
        clock_edge();
    endtask

    task automatic run_t1(input string tname);
        next_tag = 32'h0010_0000;
        for (int i = 0; i < 8; i++) begin
            drive_and_check(t1_tab[i].start, t1_tab[i].flush, t1_tab[i].ready);
            chk($sformatf("%s_r%0d_busy", tname, i), 32'(busy), 32'(t1_tab[i].busy));
            chk($sformatf("%s_r%0d_issue", tname, i), 32'(issue), 32'(t1_tab[i].issue));
            chk($sformatf("%s_r%0d_valid", tname, i), 32'(valid), 32'(t1_tab[i].valid));
            chk($sformatf("%s_r%0d_infl", tname, i), 32'(inflight),
                32'(t1_tab[i].inflight));
            chk($sformatf("%s_r%0d_result", tname, i), result, t1_tab[i].result);
            clock_edge();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] popped[$];
        int          n_iss;
        int          vcnt;
        logic        s;

        // start, flush, ready | busy, issue, valid, inflight, result
        t1_tab[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 32'h0};
        t1_tab[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 32'h0};
        t1_tab[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 32'h0};
        t1_tab[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 32'h0};
        t1_tab[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 32'h0};
        t1_tab[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 32'h0};
        t1_tab[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 32'h0010_0000};
        t1_tab[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0010_0000};

        model_reset();
        cyc      = 0;
        next_tag = 32'd0;

        // Reset state
        #2 reset = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_issue", 32'(issue), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_inflight", 32'(inflight), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // T1 single issue
        run_t1("t1");

        // T2 credit stall: start held, consumer stalled
        next_tag = 32'd1;
        n_iss    = 0;
        for (int c = 0; c < 10; c++) begin
            drive_and_check(1'b1, 1'b0, 1'b0);
            if (issue) n_iss++;
            clock_edge();
        end
        chk("t2_issues", 32'(n_iss), 32'd4);
        drive_and_check(1'b1, 1'b0, 1'b0);
        chk("t2_busy_full", 32'(busy), 32'd1);
        chk("t2_head", result, 32'd1);
        clock_edge();

        // T3 drain the full FIFO while requesting more issues
        popped.delete();
        for (int c = 0; c < 12; c++) begin
            drive_and_check(1'b1, 1'b0, 1'b1);
            if (c == 1) chk("t3_reissue", 32'(issue), 32'd1);
            if (valid && popped.size() < 4) popped.push_back(result);
            clock_edge();
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_pop%0d", i), (i < popped.size()) ? popped[i] : 32'hDEAD,
                32'(i + 1));
        end
        for (int c = 0; c < 10; c++) cycle(1'b0, 1'b0, 1'b1);

        // T4 push and pop land on the same edge with 3 queued
        next_tag = 32'h41;
        popped.delete();
        for (int c = 0; c < 16; c++) begin
            drive_and_check((c < 3) || (c == 5), 1'b0, (c >= 10));
            if (valid && ready && popped.size() < 4) popped.push_back(result);
            clock_edge();
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4_pop%0d", i), (i < popped.size()) ? popped[i] : 32'hDEAD,
                32'h41 + 32'(i));
        end

        // T5 flush with 2 queued and 2 in flight
        next_tag = 32'h51;
        vcnt     = 0;
        for (int c = 0; c < 15; c++) begin
            s = (c == 0) || (c == 1) || (c == 4) || (c == 5);
            drive_and_check(s, (c == 7), 1'b0);
            if (c == 7) chk("t5_valid_pre", 32'(valid), 32'd1);
            if (c >= 8 && valid) vcnt++;
            if (c == 10) chk("t5_busy_draining", 32'(busy), 32'd1);
            if (c == 11) chk("t5_busy_last", 32'(busy), 32'd1);
            if (c == 12) chk("t5_busy_idle", 32'(busy), 32'd0);
            clock_edge();
        end
        chk("t5_no_push", 32'(vcnt), 32'd0);

        // T6 async reset with 2 in flight and 1 queued
        next_tag = 32'h61;
        for (int c = 0; c < 6; c++) cycle((c == 0) || (c == 4) || (c == 5), 1'b0, 1'b0);
        drive_and_check(1'b0, 1'b0, 1'b0);
        chk("t6_pre_valid", 32'(valid), 32'd1);
        chk("t6_pre_inflight", 32'(inflight), 32'd2);
        #1 reset = 1'b0;
        #1;
        chk("t6_valid", 32'(valid), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_inflight", 32'(inflight), 32'd0);
        chk("t6_err", 32'(err), 32'd0);
        chk("t6_result", result, 32'd0);
        #4 reset = 1'b1;
        model_reset();
        cyc++;
        run_t1("t6");

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            next_tag = $urandom;
            cycle(($urandom_range(0, 9) < 6), ($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 1) == 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
